// File: rtl/rv_rf_pkg.sv
// Shared types and sizes for the integer register file and its debug dump engine.
package rv_rf_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    typedef logic [4:0] rf_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } dump_state_e;

endpackage

// File: rtl/rf_dump_fsm.sv
// Debug dump engine: streams x1..x(NREG-1) over a valid/ready handshake,
// one captured register value per beat, followed by a single done pulse.
module rf_dump_fsm
    import rv_rf_pkg::*;
#(
    parameter int XLEN = rv_rf_pkg::XLEN,
    parameter int NREG = rv_rf_pkg::NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREG*XLEN-1:0] rf_flat_i,
    input  logic [NREG-1:0]      wr_en_i,
    input  logic [XLEN-1:0]      wr_data_i,
    input  logic                 start_i,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic                 valid_o,
    output rf_addr_t             addr_o,
    output logic [XLEN-1:0]      data_o,
    output logic                 done_o
);

    localparam rf_addr_t LAST_IDX = rf_addr_t'(NREG - 1);

    dump_state_e     state_q, state_d;
    rf_addr_t        idx_q, idx_d;
    rf_addr_t        loadIdx;
    logic [XLEN-1:0] capture_q, capture_d;
    logic [XLEN-1:0] loadVal;

    // The next beat's value must reflect a write landing on the same edge it is captured.
    always_comb begin
        loadIdx = (state_q == IDLE) ? rf_addr_t'(1) : idx_q + rf_addr_t'(1);
        loadVal = wr_en_i[loadIdx] ? wr_data_i : rf_flat_i[loadIdx*XLEN +: XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            capture_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            capture_q <= capture_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        capture_d = capture_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = SEND;
                    idx_d     = rf_addr_t'(1);
                    capture_d = loadVal;
                end
            end
            SEND: begin
                if (ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d     = loadIdx;
                        capture_d = loadVal;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign valid_o = (state_q == SEND);
    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign addr_o  = valid_o ? idx_q : '0;
    assign data_o  = valid_o ? capture_q : '0;

endmodule

// File: rtl/regfile_reader.sv
// Integer register file storage and read side: x1..x31 written by one-hot strobes,
// two combinational read ports with x0 hardwired to zero, plus the debug dump engine.
module regfile_reader
    import rv_rf_pkg::*;
#(
    parameter int XLEN   = rv_rf_pkg::XLEN,
    parameter int NREG   = rv_rf_pkg::NREG,
    parameter int BYPASS = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREG-1:0] wr_en_onehot,
    input  logic [XLEN-1:0] wr_data,
    input  rf_addr_t        rs1_addr,
    input  rf_addr_t        rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            dump_start,
    output logic            dump_busy,
    output logic            dump_valid,
    input  logic            dump_ready,
    output rf_addr_t        dump_addr,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_done
);

    logic [XLEN-1:0]      regs_q [1:NREG-1];
    logic [NREG*XLEN-1:0] rfFlat;
    logic [XLEN-1:0]      rs1Stored;
    logic [XLEN-1:0]      rs2Stored;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_en_onehot[i]) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    // Slot 0 of the flattened view stays zero, which makes x0 read as zero for free.
    always_comb begin
        rfFlat = '0;
        for (int i = 1; i < NREG; i++) begin
            rfFlat[i*XLEN +: XLEN] = regs_q[i];
        end
    end

    assign rs1Stored = rfFlat[rs1_addr*XLEN +: XLEN];
    assign rs2Stored = rfFlat[rs2_addr*XLEN +: XLEN];

    generate
        if (BYPASS != 0) begin : g_bypass
            assign rs1_data = (rs1_addr == '0)          ? '0      :
                              wr_en_onehot[rs1_addr]    ? wr_data : rs1Stored;
            assign rs2_data = (rs2_addr == '0)          ? '0      :
                              wr_en_onehot[rs2_addr]    ? wr_data : rs2Stored;
        end else begin : g_no_bypass
            assign rs1_data = rs1Stored;
            assign rs2_data = rs2Stored;
        end
    endgenerate

    rf_dump_fsm #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_dump (
        .clk       (clk),
        .rst       (rst),
        .rf_flat_i (rfFlat),
        .wr_en_i   (wr_en_onehot),
        .wr_data_i (wr_data),
        .start_i   (dump_start),
        .ready_i   (dump_ready),
        .busy_o    (dump_busy),
        .valid_o   (dump_valid),
        .addr_o    (dump_addr),
        .data_o    (dump_data),
        .done_o    (dump_done)
    );

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: a stored-read instance and a write-through instance
// share stimulus; dump beats are scored against a queue filled from a register model.
module tb_regfile_reader;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wr_en_onehot;
    logic [31:0] wr_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        dump_start, dump_ready;

    logic [31:0] rs1_data, rs2_data, dump_data;
    logic        dump_busy, dump_valid, dump_done;
    logic [4:0]  dump_addr;

    logic [31:0] bRs1, bRs2, bDumpData;
    logic        bBusy, bValid, bDone;
    logic [4:0]  bDumpAddr;

    int          total = 0;
    int          bad = 0;
    int          gapCycles = 0;
    logic [31:0] model [32];
    beat_t       expQ [$];

    regfile_reader #(.BYPASS(0)) dut (
        .clk(clk), .rst(rst), .wr_en_onehot(wr_en_onehot), .wr_data(wr_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    regfile_reader #(.BYPASS(1)) dutByp (
        .clk(clk), .rst(rst), .wr_en_onehot(wr_en_onehot), .wr_data(wr_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(bRs1), .rs2_data(bRs2),
        .dump_start(dump_start), .dump_busy(bBusy), .dump_valid(bValid),
        .dump_ready(dump_ready), .dump_addr(bDumpAddr), .dump_data(bDumpData),
        .dump_done(bDone)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at a negedge; the write lands on the following posedge.
    task automatic write_regs(input logic [31:0] mask, input logic [31:0] data);
        wr_en_onehot = mask;
        wr_data      = data;
        @(negedge clk);
        wr_en_onehot = '0;
        for (int i = 1; i < 32; i++) if (mask[i]) model[i] = data;
    endtask

    task automatic preload();
        for (int i = 1; i < 32; i++) write_regs(32'h1 << i, 32'(i * 32'h11));
    endtask

    task automatic push_all_beats();
        expQ.delete();
        for (int i = 1; i < 32; i++) expQ.push_back('{addr: 5'(i), data: model[i]});
    endtask

    // Accepts n beats with ready high, scoring each one against the queue head.
    task automatic consume_beats(input int n);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            int guard = 0;
            while (!dump_valid && guard < 8) begin
                @(negedge clk);
                guard++;
                gapCycles++;
            end
            total++;
            if (!dump_valid || expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL beat_wait: valid=%0b queued=%0d want valid=1 with queued beat",
                         dump_valid, expQ.size());
                return;
            end
            e = expQ.pop_front();
            if (dump_addr !== e.addr || dump_data !== e.data) begin
                bad++;
                $display("[TB] FAIL beat: got addr=%0d data=%h want addr=%0d data=%h",
                         dump_addr, dump_data, e.addr, e.data);
            end
            dump_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en_onehot = '0; wr_data = '0; rs1_addr = '0; rs2_addr = '0;
        dump_start = 1'b0; dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({dump_busy, dump_valid, dump_done} !== 3'b000 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got busy/valid/done=%b addr=%0d data=%h want 000/0/0",
                     {dump_busy, dump_valid, dump_done}, dump_addr, dump_data);
        end
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            total++;
            if (rs1_data !== 32'd0 || rs2_data !== 32'd0 || bRs1 !== 32'd0 || bRs2 !== 32'd0) begin
                bad++;
                $display("[TB] FAIL reset_read a=%0d: got %h %h %h %h want all 0",
                         a, rs1_data, rs2_data, bRs1, bRs2);
            end
        end
        @(negedge clk);
        rs1_addr = 5'd0;
        wr_en_onehot = 32'h1; wr_data = 32'hDEADBEEF;
        #1;
        total++;
        if (bRs1 !== 32'd0) begin
            bad++;
            $display("[TB] FAIL x0_bypass: got %h want 00000000", bRs1);
        end
        @(negedge clk);
        wr_en_onehot = '0;
        total++;
        if (rs1_data !== 32'd0 || bRs1 !== 32'd0) begin
            bad++;
            $display("[TB] FAIL x0_write: got %h / %h want 00000000", rs1_data, bRs1);
        end
    endtask

    task automatic test_single_write();
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        wr_en_onehot = 32'h1 << 5; wr_data = 32'h12345678;
        #1;
        total++;
        if (rs1_data !== model[5] || bRs1 !== 32'h12345678 || bRs2 !== 32'h12345678) begin
            bad++;
            $display("[TB] FAIL same_cycle_x5: got stored=%h byp=%h/%h want %h / 12345678",
                     rs1_data, bRs1, bRs2, model[5]);
        end
        @(negedge clk);
        wr_en_onehot = '0;
        model[5] = 32'h12345678;
        total++;
        if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
            bad++;
            $display("[TB] FAIL read_x5: got %h %h want 12345678", rs1_data, rs2_data);
        end
    endtask

    task automatic test_multi_write();
        write_regs(32'h0000_0006, 32'hA5A5A5A5);
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        #1;
        total++;
        if (rs1_data !== 32'hA5A5A5A5 || rs2_data !== 32'hA5A5A5A5) begin
            bad++;
            $display("[TB] FAIL multi_write: got x1=%h x2=%h want a5a5a5a5", rs1_data, rs2_data);
        end
        rs2_addr = 5'd3;
        #1;
        total++;
        if (rs2_data !== 32'd0) begin
            bad++;
            $display("[TB] FAIL multi_untouched_x3: got %h want 00000000", rs2_data);
        end
    endtask

    task automatic test_dump_full();
        preload();
        push_all_beats();
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        gapCycles = 0;
        consume_beats(31);
        total++;
        if (gapCycles != 0 || expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL dump_latency: got gaps=%0d left=%0d want 0/0", gapCycles, expQ.size());
        end
        total++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dump_done: got done=%b valid=%b busy=%b want 1 0 1",
                     dump_done, dump_valid, dump_busy);
        end
        dump_start = 1'b1;
        @(negedge clk);
        total++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dump_idle_after_done: got done=%b busy=%b want 0 0", dump_done, dump_busy);
        end
    endtask

    task automatic test_back_to_back();
        push_all_beats();
        @(negedge clk);
        total++;
        if (dump_busy !== 1'b1 || dump_valid !== 1'b1 || dump_addr !== 5'd1) begin
            bad++;
            $display("[TB] FAIL back_to_back: got busy=%b valid=%b addr=%0d want 1 1 1",
                     dump_busy, dump_valid, dump_addr);
        end
        consume_beats(11);
        dump_start = 1'b0;
        total++;
        if (dump_valid !== 1'b1 || dump_addr !== 5'd12 || dump_data !== model[12]) begin
            bad++;
            $display("[TB] FAIL beat12: got valid=%b addr=%0d data=%h want 1 12 %h",
                     dump_valid, dump_addr, dump_data, model[12]);
        end
    endtask

    task automatic test_reset_abort();
        int strayBeats = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i < 32; i++) model[i] = '0;
        expQ.delete();
        total++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort: got valid=%b busy=%b done=%b want 0 0 0",
                     dump_valid, dump_busy, dump_done);
        end
        rs1_addr = 5'd12;
        #1;
        total++;
        if (rs1_data !== 32'd0) begin
            bad++;
            $display("[TB] FAIL abort_regs_clear: got %h want 00000000", rs1_data);
        end
        repeat (40) begin
            @(negedge clk);
            if (dump_valid || dump_done || dump_busy) strayBeats++;
        end
        total++;
        if (strayBeats != 0) begin
            bad++;
            $display("[TB] FAIL no_second_dump: got %0d active cycles want 0", strayBeats);
        end
    endtask

    task automatic test_stall_capture();
        preload();
        push_all_beats();
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        consume_beats(6);
        dump_ready = 1'b0;
        write_regs(32'h1 << 7, 32'hFFFF0000);
        @(negedge clk);
        rs1_addr = 5'd7;
        #1;
        total++;
        if (dump_valid !== 1'b1 || dump_addr !== 5'd7 || dump_data !== 32'h77) begin
            bad++;
            $display("[TB] FAIL stall_frozen: got valid=%b addr=%0d data=%h want 1 7 00000077",
                     dump_valid, dump_addr, dump_data);
        end
        total++;
        if (rs1_data !== 32'hFFFF0000) begin
            bad++;
            $display("[TB] FAIL read_during_dump: got %h want ffff0000", rs1_data);
        end
        wr_en_onehot = 32'h1 << 8;
        wr_data      = 32'hCAFE0008;
        expQ[1].data = 32'hCAFE0008;
        consume_beats(1);
        wr_en_onehot = '0;
        model[8] = 32'hCAFE0008;
        consume_beats(24);
        total++;
        if (dump_done !== 1'b1 || expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL stall_dump_done: got done=%b left=%0d want 1 0", dump_done, expQ.size());
        end
    endtask

    initial begin
        $display("[TB] starting regfile_reader bench");
        test_reset();
        test_single_write();
        test_multi_write();
        test_dump_full();
        test_back_to_back();
        test_reset_abort();
        test_stall_capture();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
